sram_rgb_writer: RTL and testbench



---
 rtl/rgb_writer_pkg.sv | 48 ++++
 rtl/pair_fifo.sv | 53 +++++
 rtl/sram_rgb_writer.sv | 162 ++++++++++++++++
 tb/tb_sram_rgb_writer.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/rgb_writer_pkg.sv
// Shared constants, state encoding and pixel-pair payload for the RGB SRAM writer.
package rgb_writer_pkg;

   localparam int unsigned ADDR_W = 18;
   localparam int unsigned DATA_W = 16;
   localparam int unsigned CHAN_W = 8;

   localparam logic [ADDR_W-1:0] RGB_BASE_ADDR_DEFAULT = 18'd146944;
   localparam int unsigned       NUM_PIXELS_DEFAULT    = 76800;

   // Three 16-bit words carry one pixel pair (six bytes).
   function automatic int unsigned rgb_words(input int unsigned num_pixels);
      return (3 * num_pixels) / 2;
   endfunction

   localparam int unsigned RGB_WORDS = rgb_words(NUM_PIXELS_DEFAULT);

   typedef enum logic [2:0] {
      S_IDLE,
      S_WAIT,
      S_W0,
      S_W1,
      S_W2,
      S_DONE
   } rgb_writer_state_t;

   typedef struct packed {
      logic [CHAN_W-1:0] r0;
      logic [CHAN_W-1:0] g0;
      logic [CHAN_W-1:0] b0;
      logic [CHAN_W-1:0] r1;
      logic [CHAN_W-1:0] g1;
      logic [CHAN_W-1:0] b1;
   } rgb_pair_t;

   // Word idx of a pair: {r0,g0}, {b0,r1}, {g1,b1}.
   function automatic logic [DATA_W-1:0] pair_word(input rgb_pair_t p, input logic [1:0] idx);
      logic [DATA_W-1:0] w;
      w = {p.g1, p.b1};
      case (idx)
         2'd0:    w = {p.r0, p.g0};
         2'd1:    w = {p.b0, p.r1};
         default: w = {p.g1, p.b1};
      endcase
      return w;
   endfunction

endpackage

// File: rtl/pair_fifo.sv
// Synchronous pixel-pair FIFO; exposes the head and the entry behind it
// so the writer can chain pairs without an idle cycle.
module pair_fifo
   import rgb_writer_pkg::*;
#(
   parameter int unsigned DEPTH = 4
) (
   input  logic                         Clock_50,
   input  logic                         Reset,
   input  logic                         push,
   input  rgb_pair_t                    wr_data,
   input  logic                         pop,
   output rgb_pair_t                    head,
   output rgb_pair_t                    next_head,
   output logic                         full,
   output logic                         empty,
   output logic [$clog2(DEPTH+1)-1:0]   level
);

   localparam int unsigned PW = $clog2(DEPTH);
   localparam int unsigned LW = $clog2(DEPTH + 1);

   rgb_pair_t       mem [DEPTH];
   logic [PW-1:0]   rd_ptr;
   logic [PW-1:0]   wr_ptr;
   logic            push_ok;
   logic            pop_ok;

   assign full      = (level == LW'(DEPTH));
   assign empty     = (level == '0);
   assign push_ok   = push && !full;
   assign pop_ok    = pop && !empty;
   assign head      = mem[rd_ptr];
   assign next_head = mem[rd_ptr + PW'(1)];

   always_ff @(posedge Clock_50) begin
      if (Reset) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         level  <= '0;
      end else begin
         if (push_ok) wr_ptr <= wr_ptr + PW'(1);
         if (pop_ok)  rd_ptr <= rd_ptr + PW'(1);
         level <= level + LW'(push_ok) - LW'(pop_ok);
      end
   end

   // Storage needs no reset; the pointers define what is valid.
   always_ff @(posedge Clock_50) begin
      if (push_ok) mem[wr_ptr] <= wr_data;
   end

endmodule

// File: rtl/sram_rgb_writer.sv
// Packs buffered RGB pixel pairs into three 16-bit SRAM writes each, walking
// the RGB region row-major and stalling whenever SRAM ownership is withdrawn.
module sram_rgb_writer
   import rgb_writer_pkg::*;
#(
   parameter logic [ADDR_W-1:0] RGB_BASE_ADDR = RGB_BASE_ADDR_DEFAULT,
   parameter int unsigned       NUM_PIXELS    = NUM_PIXELS_DEFAULT,
   parameter int unsigned       FIFO_DEPTH    = 4
) (
   input  logic                Clock_50,
   input  logic                Reset,
   input  logic                Start,
   input  logic                pix_valid,
   output logic                pix_ready,
   input  logic [CHAN_W-1:0]   pix_r0,
   input  logic [CHAN_W-1:0]   pix_g0,
   input  logic [CHAN_W-1:0]   pix_b0,
   input  logic [CHAN_W-1:0]   pix_r1,
   input  logic [CHAN_W-1:0]   pix_g1,
   input  logic [CHAN_W-1:0]   pix_b1,
   input  logic                SRAM_grant,
   output logic [ADDR_W-1:0]   SRAM_address,
   output logic [DATA_W-1:0]   SRAM_write_data,
   output logic                SRAM_we_n,
   output logic                Busy,
   output logic                Done
);

   localparam int unsigned PAIRS = NUM_PIXELS / 2;
   localparam int unsigned CW    = $clog2(PAIRS + 1);
   localparam int unsigned LW    = $clog2(FIFO_DEPTH + 1);

   rgb_writer_state_t state;
   rgb_pair_t         pix_pair;
   rgb_pair_t         head;
   rgb_pair_t         next_head;
   logic              full;
   logic              empty;
   logic [LW-1:0]     level;
   logic [LW-1:0]     level_nxt;
   logic [CW-1:0]     pairs_accepted;
   logic [CW-1:0]     pairs_written;
   logic [CW-1:0]     acc_nxt;
   logic              busy_nxt;
   logic              ready_nxt;
   logic              push;
   logic              pop;
   logic              commit;
   logic              last_pair;

   assign pix_pair  = {pix_r0, pix_g0, pix_b0, pix_r1, pix_g1, pix_b1};
   assign push      = pix_valid && pix_ready && !full;
   // A word is written only on a cycle where it is driven and the port is owned.
   assign commit    = !SRAM_we_n && SRAM_grant;
   assign pop       = (state == S_W2) && commit;
   assign last_pair = (pairs_written == CW'(PAIRS - 1));

   pair_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
      .Clock_50  (Clock_50),
      .Reset     (Reset),
      .push      (push),
      .wr_data   (pix_pair),
      .pop       (pop),
      .head      (head),
      .next_head (next_head),
      .full      (full),
      .empty     (empty),
      .level     (level)
   );

   // pix_ready is a flop, so it is computed from next-cycle Busy/occupancy/count.
   always_comb begin
      busy_nxt  = Busy;
      acc_nxt   = pairs_accepted + CW'(push);
      level_nxt = level + LW'(push) - LW'(pop);
      if (state == S_IDLE && Start) begin
         busy_nxt = 1'b1;
         acc_nxt  = '0;
      end
      if (state == S_DONE) busy_nxt = 1'b0;
      ready_nxt = busy_nxt && (level_nxt != LW'(FIFO_DEPTH)) && (acc_nxt < CW'(PAIRS));
   end

   always_ff @(posedge Clock_50) begin
      if (Reset) begin
         state           <= S_IDLE;
         SRAM_we_n       <= 1'b1;
         SRAM_address    <= RGB_BASE_ADDR;
         SRAM_write_data <= '0;
         pix_ready       <= 1'b0;
         Busy            <= 1'b0;
         Done            <= 1'b0;
         pairs_accepted  <= '0;
         pairs_written   <= '0;
      end else begin
         Done      <= 1'b0;
         pix_ready <= ready_nxt;
         if (push) pairs_accepted <= pairs_accepted + CW'(1);

         case (state)
            S_IDLE: begin
               if (Start) begin
                  pairs_accepted <= '0;
                  pairs_written  <= '0;
                  SRAM_address   <= RGB_BASE_ADDR;
                  Busy           <= 1'b1;
                  state          <= S_WAIT;
               end
            end

            S_WAIT: begin
               if (!empty && SRAM_grant) begin
                  SRAM_write_data <= pair_word(head, 2'd0);
                  SRAM_we_n       <= 1'b0;
                  state           <= S_W0;
               end else begin
                  SRAM_we_n <= 1'b1;
               end
            end

            S_W0, S_W1, S_W2: begin
               if (!commit) begin
                  // Hold address/data; re-drive the same word once grant is back.
                  SRAM_we_n <= !SRAM_grant;
               end else if (state == S_W0) begin
                  SRAM_address    <= SRAM_address + ADDR_W'(1);
                  SRAM_write_data <= pair_word(head, 2'd1);
                  state           <= S_W1;
               end else if (state == S_W1) begin
                  SRAM_address    <= SRAM_address + ADDR_W'(1);
                  SRAM_write_data <= pair_word(head, 2'd2);
                  state           <= S_W2;
               end else begin
                  pairs_written <= pairs_written + CW'(1);
                  if (last_pair) begin
                     SRAM_we_n <= 1'b1;
                     Done      <= 1'b1;
                     state     <= S_DONE;
                  end else begin
                     SRAM_address <= SRAM_address + ADDR_W'(1);
                     if (level > LW'(1)) begin
                        SRAM_write_data <= pair_word(next_head, 2'd0);
                        state           <= S_W0;
                     end else begin
                        SRAM_we_n <= 1'b1;
                        state     <= S_WAIT;
                     end
                  end
               end
            end

            S_DONE: begin
               Busy  <= 1'b0;
               state <= S_IDLE;
            end

            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_sram_rgb_writer.sv
// Randomized bench for sram_rgb_writer: an in-order word scoreboard built from
// accepted pixel pairs, using a small frame placed at the very top of SRAM.
module tb_sram_rgb_writer;
   import rgb_writer_pkg::*;

   localparam int unsigned NPIX  = 64;
   localparam int unsigned PAIRS = NPIX / 2;
   localparam int unsigned WORDS = 3 * PAIRS;
   localparam int unsigned DEPTH = 4;
   localparam logic [17:0] BASE  = 18'd262048;   // last word lands on 262143

   logic        clk = 1'b0;
   logic        Reset, Start, pix_valid, pix_ready, SRAM_grant, SRAM_we_n, Busy, Done;
   logic [7:0]  pix_r0, pix_g0, pix_b0, pix_r1, pix_g1, pix_b1;
   logic [17:0] SRAM_address;
   logic [15:0] SRAM_write_data;

   always #5 clk = ~clk;

   sram_rgb_writer #(.RGB_BASE_ADDR(BASE), .NUM_PIXELS(NPIX), .FIFO_DEPTH(DEPTH)) dut (
      .Clock_50        (clk),
      .Reset           (Reset),
      .Start           (Start),
      .pix_valid       (pix_valid),
      .pix_ready       (pix_ready),
      .pix_r0          (pix_r0),
      .pix_g0          (pix_g0),
      .pix_b0          (pix_b0),
      .pix_r1          (pix_r1),
      .pix_g1          (pix_g1),
      .pix_b1          (pix_b1),
      .SRAM_grant      (SRAM_grant),
      .SRAM_address    (SRAM_address),
      .SRAM_write_data (SRAM_write_data),
      .SRAM_we_n       (SRAM_we_n),
      .Busy            (Busy),
      .Done            (Done)
   );

   int n_checks = 0;
   int n_fail   = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   // Source side
   logic [47:0] src[$];
   int          src_idx      = 0;
   int          valid_pct    = 100;
   int          grant_pct    = 100;
   bit          grant_manual = 1'b1;

   // Reference model: pairs in acceptance order, word stream 3 per pair
   logic [47:0] acc_pairs[$];
   int          wr_idx = 0;
   int          wr_cnt[WORDS];
   logic [15:0] wlog[4];
   int          cyc = 0, first_wr_cyc = 0, last_wr_cyc = 0, done_cnt = 0;
   logic [47:0] m_pair;
   logic [15:0] m_word;

   always @(negedge clk) begin
      cyc++;
      if (Reset || (Start && !Busy)) begin
         acc_pairs.delete();
         wr_idx       = 0;
         first_wr_cyc = 0;
         last_wr_cyc  = 0;
         for (int i = 0; i < WORDS; i++) wr_cnt[i] = 0;
      end else begin
         if (!SRAM_we_n && SRAM_grant) begin
            check("wr_has_pair", 32'(wr_idx < 3 * acc_pairs.size()), 32'd1);
            check("wr_addr", 32'(SRAM_address), 32'(BASE) + 32'(wr_idx));
            if (wr_idx < 3 * acc_pairs.size()) begin
               m_pair = acc_pairs[wr_idx / 3];
               m_word = 16'(m_pair >> (32 - 16 * (wr_idx % 3)));
               check("wr_data", 32'(SRAM_write_data), 32'(m_word));
            end
            if (wr_idx < WORDS) wr_cnt[wr_idx]++;
            if (wr_idx < 3) wlog[wr_idx[1:0]] = SRAM_write_data;
            if (wr_idx == 0) first_wr_cyc = cyc;
            last_wr_cyc = cyc;
            wr_idx++;
         end
         if (pix_valid && pix_ready)
            acc_pairs.push_back({pix_r0, pix_g0, pix_b0, pix_r1, pix_g1, pix_b1});
         if (Done) begin
            done_cnt++;
            check("done_words", 32'(wr_idx), 32'(WORDS));
            check("done_after_last_word", 32'(cyc - last_wr_cyc), 32'd1);
         end
      end
   end

   task automatic drive();
      if (src_idx < src.size() && (valid_pct >= 100 || $urandom_range(99) < valid_pct)) begin
         pix_valid = 1'b1;
         {pix_r0, pix_g0, pix_b0, pix_r1, pix_g1, pix_b1} = src[src_idx];
      end else begin
         pix_valid = 1'b0;
      end
      if (!grant_manual) SRAM_grant = ($urandom_range(99) < grant_pct);
   endtask

   task automatic tick();
      bit hs;
      @(negedge clk);
      hs = pix_valid && pix_ready;
      @(posedge clk);
      #1;
      if (hs) src_idx++;
      drive();
   endtask

   task automatic pulse_start();
      Start = 1'b1;
      tick();
      Start = 1'b0;
   endtask

   task automatic wait_writes(input int n, input int bound);
      int k = 0;
      while (wr_idx < n && k < bound) begin
         tick();
         k++;
      end
      check("wait_writes_reached", 32'(wr_idx >= n), 32'd1);
   endtask

   task automatic wait_done(input int bound);
      int k  = 0;
      int d0 = done_cnt;
      while (done_cnt == d0 && k < bound) begin
         tick();
         k++;
      end
      check("done_pulses", 32'(done_cnt - d0), 32'd1);
      check("done_single_cycle", 32'(Done), 32'd0);
      check("busy_after_done", 32'(Busy), 32'd0);
   endtask

   task automatic check_coverage();
      for (int i = 0; i < WORDS; i++) check("word_written_once", 32'(wr_cnt[i]), 32'd1);
   endtask

   task automatic load_random(input int n);
      src.delete();
      src_idx = 0;
      for (int k = 0; k < n; k++) src.push_back(48'({$urandom, $urandom}));
   endtask

   task automatic load_index_pattern(input int n);
      logic [7:0] a, b;
      src.delete();
      src_idx = 0;
      for (int k = 0; k < n; k++) begin
         a = 8'((2 * k) % 256);
         b = 8'((2 * k + 1) % 256);
         src.push_back({a, a, a, b, b, b});
      end
   endtask

   initial begin
      Reset = 1'b1; Start = 1'b0; pix_valid = 1'b0; SRAM_grant = 1'b1;
      {pix_r0, pix_g0, pix_b0, pix_r1, pix_g1, pix_b1} = '0;
      repeat (3) tick();
      check("rst_we_n", 32'(SRAM_we_n), 32'd1);
      check("rst_addr", 32'(SRAM_address), 32'(BASE));
      check("rst_data", 32'(SRAM_write_data), 32'd0);
      check("rst_ready", 32'(pix_ready), 32'd0);
      check("rst_busy", 32'(Busy), 32'd0);
      check("rst_done", 32'(Done), 32'd0);
      Reset = 1'b0;
      tick();

      // Frame A: known first pair, then reset in the middle of pair 3
      load_random(PAIRS);
      src[0] = 48'h112233445566;
      valid_pct = 100; grant_manual = 1'b1; SRAM_grant = 1'b1;
      pulse_start();
      wait_writes(3, 50);
      check("pair0_word0", 32'(wlog[0]), 32'h1122);
      check("pair0_word1", 32'(wlog[1]), 32'h3344);
      check("pair0_word2", 32'(wlog[2]), 32'h5566);
      check("busy_mid_frame", 32'(Busy), 32'd1);
      wait_writes(10, 100);
      Reset = 1'b1;
      tick();
      check("midrst_we_n", 32'(SRAM_we_n), 32'd1);
      check("midrst_busy", 32'(Busy), 32'd0);
      check("midrst_addr", 32'(SRAM_address), 32'(BASE));
      check("midrst_ready", 32'(pix_ready), 32'd0);
      Reset = 1'b0;
      tick();

      // Frame B: grant dropped after word1 of pair 0, stray Start while busy
      load_random(PAIRS);
      valid_pct = 70; grant_manual = 1'b1; SRAM_grant = 1'b1;
      pulse_start();
      wait_writes(2, 50);
      SRAM_grant = 1'b0;
      repeat (5) tick();
      check("no_write_without_grant", 32'(wr_idx), 32'd2);
      check("we_n_idle_without_grant", 32'(SRAM_we_n), 32'd1);
      SRAM_grant = 1'b1;
      grant_manual = 1'b0; grant_pct = 85;
      wait_writes(3, 20);
      wait_writes(20, 400);
      pulse_start();
      wait_done(3000);
      check_coverage();

      // Frame C: grant withheld with valid held high, surplus source pairs
      load_index_pattern(PAIRS + 8);
      valid_pct = 100; grant_manual = 1'b1; SRAM_grant = 1'b0;
      pulse_start();
      repeat (20) tick();
      check("accepted_while_no_grant", 32'(acc_pairs.size()), 32'(DEPTH));
      check("ready_low_when_full", 32'(pix_ready), 32'd0);
      check("no_write_before_grant", 32'(wr_idx), 32'd0);
      SRAM_grant = 1'b1;
      wait_done(1000);
      check("accepted_frame_pairs", 32'(acc_pairs.size()), 32'(PAIRS));
      check("back_to_back_words", 32'(last_wr_cyc - first_wr_cyc), 32'(WORDS - 1));
      check_coverage();
      repeat (3) tick();
      check("ready_low_after_frame", 32'(pix_ready), 32'd0);
      check("no_extra_writes", 32'(wr_idx), 32'(WORDS));

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
